// File: rtl/seq_mul_unit.sv
// Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
// Multiplies operand magnitudes, then applies a single sign-fix step before the result is registered.
module seq_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            mul_done,
  output logic [XLEN-1:0] mul_res
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one multiplier bit per cycle, LSB first
  // FIX   | conditional negate, select result half
  // DONE  | mul_done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CntW = $clog2(XLEN);

  state_t              state_q;
  logic [1:0]          ctl_q;
  logic                sa_q, sb_q;
  logic [2*XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]     mplier_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q, done_q;
  logic [XLEN-1:0]     res_q;

  logic                sa_d, sb_d;
  logic [XLEN-1:0]     a_mag_d, b_mag_d;
  logic [2*XLEN-1:0]   prod_d;

  always_comb begin
    sa_d    = rs1[XLEN-1] & ((mulctl == 2'b01) | (mulctl == 2'b10));
    sb_d    = rs2[XLEN-1] & (mulctl == 2'b01);
    a_mag_d = sa_d ? (~rs1 + XLEN'(1)) : rs1;
    b_mag_d = sb_d ? (~rs2 + XLEN'(1)) : rs2;
    prod_d  = (sa_q ^ sb_q) ? (~acc_q + (2*XLEN)'(1)) : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ctl_q    <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !kill) begin
            ctl_q    <= mulctl;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mcand_q  <= {{XLEN{1'b0}}, a_mag_d};
            mplier_q <= b_mag_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // shifting the multiplicand each step equals adding it shifted by count
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(XLEN-1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            res_q   <= (ctl_q == 2'b00) ? prod_d[XLEN-1:0] : prod_d[2*XLEN-1:XLEN];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign mul_done = done_q;
  assign mul_res  = res_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: scoreboard queue filled at issue, drained by a done monitor.
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mulctl;
  logic [31:0] rs1, rs2;
  logic        kill;
  logic        busy, mul_done;
  logic [31:0] mul_res;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  seq_mul_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mulctl(mulctl), .rs1(rs1), .rs2(rs2),
    .kill(kill), .busy(busy), .mul_done(mul_done), .mul_res(mul_res)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [1:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (c == 2'b01 || c == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (c == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (c == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!rst && mul_done) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_done", {32'b0, mul_res}, 64'h0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check(mul_res === e, "result", {32'b0, mul_res}, {32'b0, e});
      end
    end
  end

  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mulctl = c; rs1 = a; rs2 = b;
  endtask

  task automatic scramble();
    rs1 = $urandom; rs2 = $urandom; mulctl = 2'($urandom_range(0, 3));
  endtask

  task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    bit busy_ok, got;
    @(negedge clk);
    issue(c, a, b);
    exp_q.push_back(ref_mul(c, a, b));
    last_res = ref_mul(c, a, b);
    @(negedge clk);
    start = 1'b0;
    scramble();
    cyc = 1; busy_ok = 1'b1; got = 1'b0;
    while (cyc <= 100) begin
      if (!busy) busy_ok = 1'b0;
      if (mul_done) begin got = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    check(got && cyc == 34, "latency", 64'(cyc), 64'd34);
    check(busy_ok, "busy_during_op", {63'b0, busy_ok}, 64'd1);
    @(negedge clk);
    check(busy == 1'b0, "busy_after_done", {63'b0, busy}, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; mulctl = 2'b00; rs1 = '0; rs2 = '0;
    last_res = '0;
    idle_cycles(3);
    check(busy == 1'b0 && mul_done == 1'b0 && mul_res == 32'h0, "reset_state",
          {31'b0, busy, mul_done, mul_res}, 64'h0);
    rst = 1'b0;

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'b01, 32'h80000000, 32'h80000000);
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000001);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'b10, 32'h00000002, 32'h80000000);
    run_op(2'b01, 32'h00000000, 32'h80000000);
    run_op(2'b00, 32'h00000007, 32'hFFFFFFFD);
    run_op(2'b01, 32'h80000000, 32'h00000001);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF);

    for (int i = 0; i < 16; i++)
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom);

    // start held high: accepts only in IDLE, so one op per 35 cycles
    begin
      int cyc, d1, d2, nd;
      @(negedge clk);
      issue(2'b01, 32'h12345678, 32'hF0000001);
      exp_q.push_back(ref_mul(2'b01, 32'h12345678, 32'hF0000001));
      exp_q.push_back(ref_mul(2'b01, 32'h12345678, 32'hF0000001));
      last_res = ref_mul(2'b01, 32'h12345678, 32'hF0000001);
      cyc = 0; nd = 0; d1 = 0; d2 = 0;
      while (cyc < 200 && nd < 2) begin
        @(negedge clk);
        cyc++;
        if (mul_done) begin
          nd++;
          if (nd == 1) d1 = cyc; else d2 = cyc;
        end
      end
      start = 1'b0;
      check(d1 == 34, "held_first_done", 64'(d1), 64'd34);
      check(d2 == 69, "held_second_done", 64'(d2), 64'd69);
      @(negedge clk);
      check(busy == 1'b0, "start_in_done_ignored", {63'b0, busy}, 64'd0);
      idle_cycles(40);
    end

    // kill in CALC cycle 10
    @(negedge clk);
    issue(2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
    @(negedge clk); start = 1'b0;
    idle_cycles(9);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    check(busy == 1'b0, "kill_calc_idle", {63'b0, busy}, 64'd0);
    idle_cycles(40);
    check(mul_res == last_res, "kill_calc_hold", {32'b0, mul_res}, {32'b0, last_res});

    // kill in FIX
    @(negedge clk);
    issue(2'b00, 32'h00000003, 32'h00000005);
    @(negedge clk); start = 1'b0;
    idle_cycles(32);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    check(busy == 1'b0, "kill_fix_idle", {63'b0, busy}, 64'd0);
    idle_cycles(40);
    check(mul_res == last_res, "kill_fix_hold", {32'b0, mul_res}, {32'b0, last_res});

    // kill together with start in IDLE
    @(negedge clk);
    issue(2'b00, 32'h00000009, 32'h00000009);
    kill = 1'b1;
    @(negedge clk); start = 1'b0; kill = 1'b0;
    check(busy == 1'b0, "kill_start_idle", {63'b0, busy}, 64'd0);
    idle_cycles(40);

    // async reset between edges mid-CALC
    @(negedge clk);
    issue(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF);
    @(negedge clk); start = 1'b0;
    idle_cycles(14);
    #2 rst = 1'b1;
    #1;
    check(busy == 1'b0 && mul_done == 1'b0 && mul_res == 32'h0, "async_rst",
          {31'b0, busy, mul_done, mul_res}, 64'h0);
    #1 rst = 1'b0;
    last_res = '0;
    idle_cycles(40);

    run_op(2'b11, 32'h00010000, 32'h00010000);

    check(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
